// File: rtl/mips_io_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states,
// register offsets and STATUS bit layout.
package mips_io_pkg;

   // Transmit FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   // Register offsets relative to BASE_ADDR
   localparam logic [31:0] DATA_OFS = 32'd0;
   localparam logic [31:0] STAT_OFS = 32'd4;

   // STATUS word bit positions
   localparam int ST_FULL    = 0;
   localparam int ST_EMPTY   = 1;
   localparam int ST_BUSY    = 2;
   localparam int ST_OVF     = 3;
   localparam int ST_CNT_LSB = 4;
   localparam int ST_CNT_W   = 4;

   // Assemble the zero-extended STATUS word from its fields
   function automatic logic [31:0] pack_status(input logic full,
                                               input logic empty,
                                               input logic busy,
                                               input logic ovf,
                                               input logic [ST_CNT_W-1:0] cnt);
      logic [31:0] w;
      w = 32'd0;
      w[ST_FULL]  = full;
      w[ST_EMPTY] = empty;
      w[ST_BUSY]  = busy;
      w[ST_OVF]   = ovf;
      w[ST_CNT_LSB +: ST_CNT_W] = cnt;
      return w;
   endfunction

endpackage

// File: rtl/uart_tx_port_if.sv
// Data-memory bus slice seen by the UART: the core drives address, store
// data and strobes; the UART returns its OR-able load data.
interface uart_tx_port_if;
   import mips_io_pkg::*;

   logic [31:0] Address;
   logic [31:0] WriteData;
   logic        MemWrite;
   logic        MemRead;
   logic [31:0] ReadData;

   modport master (
      output Address, WriteData, MemWrite, MemRead,
      input  ReadData
   );

   modport slave (
      input  Address, WriteData, MemWrite, MemRead,
      output ReadData
   );

endinterface

// File: rtl/byte_fifo.sv
// Small byte FIFO with combinational head output. Pushes while full and
// pops while empty are ignored so the caller cannot corrupt the pointers.
module byte_fifo
   import mips_io_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [7:0]                 din,
   output logic [7:0]                 dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Byte storage; contents need no reset because empty gates every read
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: address decode, sticky overflow flag,
// byte FIFO and a bit-serialising FSM with a per-bit baud counter.
module uart_tx_port
   import mips_io_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
   parameter int          BAUD_DIV   = 434,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic           clk,
   input  logic           reset,
   uart_tx_port_if.slave  bus,
   output logic           TxD,
   output logic           TxBusy
);

   localparam int CNT_W  = $clog2(BAUD_DIV);
   localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_DIV - 1);

   logic              wr_hit;
   logic              rd_hit;
   logic              ovf;
   logic              fifo_full;
   logic              fifo_empty;
   logic [7:0]        fifo_dout;
   logic [FCNT_W-1:0] fifo_count;
   logic              pop;
   logic              unused_wdata;

   tx_state_t         state;
   tx_state_t         state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic [2:0]        bit_idx;
   logic [2:0]        bit_nxt;
   logic [7:0]        shift;
   logic [7:0]        shift_nxt;
   logic              txd_nxt;
   logic              busy_nxt;

   assign wr_hit = bus.MemWrite && (bus.Address == BASE_ADDR + DATA_OFS);
   assign rd_hit = bus.MemRead  && (bus.Address == BASE_ADDR + STAT_OFS);

   // Only the low byte of a store is transmitted
   assign unused_wdata = ^bus.WriteData[31:8];

   // Status is a pure function of registered state, so it shows pre-edge values
   assign bus.ReadData = rd_hit ?
      pack_status(fifo_full, fifo_empty, TxBusy, ovf, ST_CNT_W'(fifo_count)) :
      32'd0;

   byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr_hit && !fifo_full),
      .pop   (pop),
      .din   (bus.WriteData[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Sticky overflow: a dropped write sets it, a status read clears it, set wins
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf <= 1'b0;
      end else if (wr_hit && fifo_full) begin
         ovf <= 1'b1;
      end else if (rd_hit) begin
         ovf <= 1'b0;
      end
   end

   // FSM control registers, including the registered line and busy outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         TxD     <= 1'b1;
         TxBusy  <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bit_idx <= bit_nxt;
         TxD     <= txd_nxt;
         TxBusy  <= busy_nxt;
      end
   end

   // Shift register holds only data; it is always loaded by a pop before use
   always_ff @(posedge clk) begin
      shift <= shift_nxt;
   end

   // Next-state logic; TxD is precomputed so each level lands on the edge it starts
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      bit_nxt   = bit_idx;
      shift_nxt = shift;
      txd_nxt   = TxD;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            txd_nxt = 1'b1;
            if (!fifo_empty) begin
               pop       = 1'b1;
               shift_nxt = fifo_dout;
               cnt_nxt   = CNT_MAX;
               state_nxt = START;
               txd_nxt   = 1'b0;
            end
         end
         START: begin
            if (cnt == '0) begin
               cnt_nxt   = CNT_MAX;
               bit_nxt   = 3'd0;
               state_nxt = DATA;
               txd_nxt   = shift[0];
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         DATA: begin
            if (cnt == '0) begin
               cnt_nxt = CNT_MAX;
               if (bit_idx == 3'd7) begin
                  state_nxt = STOP;
                  txd_nxt   = 1'b1;
               end else begin
                  shift_nxt = {1'b0, shift[7:1]};
                  bit_nxt   = bit_idx + 3'd1;
                  txd_nxt   = shift[1];
               end
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         STOP: begin
            if (cnt == '0) begin
               if (!fifo_empty) begin
                  pop       = 1'b1;
                  shift_nxt = fifo_dout;
                  cnt_nxt   = CNT_MAX;
                  state_nxt = START;
                  txd_nxt   = 1'b0;
               end else begin
                  state_nxt = IDLE;
                  txd_nxt   = 1'b1;
               end
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            txd_nxt   = 1'b1;
         end
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

endmodule

// File: tb/tb_uart_tx_port.sv
// Bench for uart_tx_port: a frame-level model (byte queue, overflow flag and
// position within the current 10-bit frame) predicts ReadData every cycle and
// TxD/TxBusy after every edge, under directed and random bus traffic.
module tb_uart_tx_port;

   localparam logic [31:0] BASE = 32'h1001_0000;
   localparam int          B    = 4;
   localparam int          D    = 4;

   logic clk;
   logic reset;
   logic TxD;
   logic TxBusy;

   uart_tx_port_if bus ();

   uart_tx_port #(
      .BASE_ADDR  (BASE),
      .BAUD_DIV   (B),
      .FIFO_DEPTH (D)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .bus    (bus.slave),
      .TxD    (TxD),
      .TxBusy (TxBusy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   logic [7:0] m_q [$];
   bit         m_ovf;
   bit         m_active;
   int         m_t;
   logic [7:0] m_byte;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   function automatic logic m_txd();
      int b;
      if (!m_active) return 1'b1;
      b = m_t / B;
      if (b == 0) return 1'b0;
      if (b <= 8) return m_byte[b-1];
      return 1'b1;
   endfunction

   function automatic logic [31:0] m_status();
      logic [31:0] w;
      w = 32'd0;
      w[0]   = (m_q.size() == D);
      w[1]   = (m_q.size() == 0);
      w[2]   = m_active;
      w[3]   = m_ovf;
      w[7:4] = 4'(m_q.size());
      return w;
   endfunction

   function automatic void m_reset();
      m_q.delete();
      m_ovf    = 0;
      m_active = 0;
      m_t      = 0;
   endfunction

   task automatic bus_idle();
      bus.Address   = 32'd0;
      bus.WriteData = 32'd0;
      bus.MemWrite  = 1'b0;
      bus.MemRead   = 1'b0;
   endtask

   // one bus cycle: drive, check load data, clock, advance model, check line
   task automatic cycle(input logic [31:0] addr, input logic [31:0] wd,
                        input bit mw, input bit mr);
      bit wr, rd, full_before;
      bus.Address   = addr;
      bus.WriteData = wd;
      bus.MemWrite  = mw;
      bus.MemRead   = mr;
      #1;
      wr = mw && (addr == BASE);
      rd = mr && (addr == BASE + 32'd4);
      chk("rdata", bus.ReadData, rd ? m_status() : 32'd0);
      @(posedge clk);
      full_before = (m_q.size() == D);
      if (m_active) begin
         if (m_t == 10*B - 1) begin
            if (m_q.size() > 0) begin
               m_byte = m_q.pop_front();
               m_t    = 0;
            end else begin
               m_active = 0;
            end
         end else begin
            m_t++;
         end
      end else if (m_q.size() > 0) begin
         m_byte   = m_q.pop_front();
         m_active = 1;
         m_t      = 0;
      end
      if (wr && !full_before) m_q.push_back(wd[7:0]);
      if (wr && full_before) m_ovf = 1;
      else if (rd) m_ovf = 0;
      #1;
      chk("txd", {31'd0, TxD}, {31'd0, m_txd()});
      chk("busy", {31'd0, TxBusy}, {31'd0, m_active});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(32'd0, 32'd0, 0, 0);
   endtask

   task automatic wr_byte(input logic [7:0] b);
      cycle(BASE, {24'hDEAD_BE, b}, 1, 0);
   endtask

   task automatic rd_stat();
      cycle(BASE + 32'd4, 32'd0, 0, 1);
   endtask

   // asynchronous reset between edges, checked before any clock edge
   task automatic async_reset();
      bus_idle();
      #2;
      reset = 1'b0;
      m_reset();
      #1;
      chk("rst_txd", {31'd0, TxD}, 32'd1);
      chk("rst_busy", {31'd0, TxBusy}, 32'd0);
      bus.Address = BASE + 32'd4;
      bus.MemRead = 1'b1;
      #1;
      chk("rst_stat", bus.ReadData, 32'h0000_0002);
      bus_idle();
      #1;
      reset = 1'b1;
   endtask

   initial begin
      bus_idle();
      m_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("init_txd", {31'd0, TxD}, 32'd1);
      chk("init_busy", {31'd0, TxBusy}, 32'd0);
      #3;
      reset = 1'b1;
      @(posedge clk);
      #1;

      // reset state and status
      rd_stat();
      idle(2);

      // single frame
      wr_byte(8'hA5);
      idle(45);

      // burst filling the FIFO, plus one dropped write
      for (int i = 1; i <= 6; i++) wr_byte(8'(i));
      rd_stat();
      rd_stat();
      // dropped write coincident with nothing, then read pair
      wr_byte(8'h77);
      rd_stat();
      rd_stat();

      // non-decoded addresses
      cycle(BASE + 32'd8, 32'h0000_0055, 1, 0);
      cycle(BASE, 32'd0, 0, 1);
      cycle(BASE + 32'd1, 32'h0000_0066, 1, 1);
      cycle(BASE + 32'd5, 32'd0, 0, 1);
      idle(10*B*6);
      rd_stat();

      // reset mid-frame at data bit 3, then a clean frame
      wr_byte(8'h3C);
      wr_byte(8'hC3);
      while (!(m_active && (m_t / B) == 4)) cycle(32'd0, 32'd0, 0, 0);
      async_reset();
      rd_stat();
      wr_byte(8'h96);
      idle(45);
      rd_stat();

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = $urandom_range(0, 19);
         case (r)
            0, 1, 2:  wr_byte(8'($urandom));
            3, 4:     rd_stat();
            5:        cycle(BASE + 32'(4 * $urandom_range(2, 5)), $urandom, 1, 1);
            6:        cycle(BASE + 32'($urandom_range(1, 3)), $urandom, 1, 0);
            7:        cycle(BASE, $urandom, 1, 1);
            8:        cycle(BASE + 32'd4, $urandom, 1, 1);
            default:  cycle(32'($urandom), $urandom, 0, 0);
         endcase
      end
      idle(10*B*(D+2));
      rd_stat();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
